// File: rtl/fine_phase_shift_sequencer.sv
// fine_phase_shift_sequencer: initiator side of the fine phase-shift handshake.
// Takes an absolute target phase, picks the shortest wrap-around direction and
// issues one incr/decr step at a time, waiting for dready after each step.
// Optional feature macro: FINEPS_TIMEOUT_EN (abandon a step whose dready never returns).
module fine_phase_shift_sequencer #(
  parameter int unsigned INT_PS_STEPS_PER_PERIOD = 504,
  parameter int unsigned INT_TIMEOUT_CYCLES      = 64,
  localparam int unsigned POS_W = $clog2(INT_PS_STEPS_PER_PERIOD)
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_cmd_valid,
  input  logic [POS_W-1:0] in_cmd_target,
  output logic             out_cmd_ready,
  input  logic             in_abort,
  output logic             out_fineps_incr,
  output logic             out_fineps_decr,
  output logic             out_fineps_valid,
  input  logic             in_fineps_dready,
  output logic [POS_W-1:0] out_position,
  output logic [POS_W-1:0] out_steps_remaining,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_cmd_err,
  output logic             out_timeout
);

  if (INT_PS_STEPS_PER_PERIOD < 2 || INT_TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("fine_phase_shift_sequencer: illegal parameter combination");
  end

  localparam logic [POS_W:0]   N_EXT    = (POS_W+1)'(INT_PS_STEPS_PER_PERIOD);
  localparam logic [POS_W:0]   HALF_EXT = (POS_W+1)'(INT_PS_STEPS_PER_PERIOD / 2);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(INT_PS_STEPS_PER_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] rem_q, rem_d;
  logic             dir_incr_q, dir_incr_d;
  logic             abort_q, abort_d;
  logic             valid_q, valid_d;
  logic             incr_q, incr_d;
  logic             decr_q, decr_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [POS_W:0]   tgt_ext, pos_ext, fwd_dist, back_dist;
  logic [POS_W-1:0] next_pos;
  logic             transfer;

`ifdef FINEPS_TIMEOUT_EN
  localparam int unsigned  TMO_W    = $clog2(INT_TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(INT_TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  assign transfer = valid_q & in_fineps_dready;

  // Forward (incr) distance to the target modulo N, and its complement (decr)
  always_comb begin
    tgt_ext = {1'b0, in_cmd_target};
    pos_ext = {1'b0, pos_q};
    if (tgt_ext >= pos_ext) fwd_dist = tgt_ext - pos_ext;
    else                    fwd_dist = tgt_ext + N_EXT - pos_ext;
    back_dist = N_EXT - fwd_dist;
  end

  // Position after completing one step in the latched direction, with wrap
  always_comb begin
    next_pos = pos_q;
    if (dir_incr_q) next_pos = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
    else            next_pos = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    rem_d      = rem_q;
    dir_incr_d = dir_incr_q;
    abort_d    = abort_q;
    valid_d    = valid_q;
    incr_d     = incr_q;
    decr_d     = decr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef FINEPS_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (in_cmd_valid && ready_q) begin
          if (tgt_ext >= N_EXT) begin
            err_d = 1'b1;
          end else if (fwd_dist == '0) begin
            done_d = 1'b1;
          end else if (fwd_dist <= HALF_EXT) begin
            dir_incr_d = 1'b1;
            rem_d      = POS_W'(fwd_dist);
            valid_d    = 1'b1;
            incr_d     = 1'b1;
            decr_d     = 1'b0;
            state_d    = S_STEP;
          end else begin
            dir_incr_d = 1'b0;
            rem_d      = POS_W'(back_dist);
            valid_d    = 1'b1;
            incr_d     = 1'b0;
            decr_d     = 1'b1;
            state_d    = S_STEP;
          end
        end
      end

      S_STEP: begin
        if (transfer) begin
          // An abort coinciding with the transfer leaves the step outstanding
          abort_d = abort_q | in_abort;
          valid_d = 1'b0;
          incr_d  = 1'b0;
          decr_d  = 1'b0;
          state_d = S_WAIT_DONE;
`ifdef FINEPS_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else if (in_abort) begin
          valid_d = 1'b0;
          incr_d  = 1'b0;
          decr_d  = 1'b0;
          rem_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WAIT_DONE: begin
        abort_d = abort_q | in_abort;
        if (in_fineps_dready) begin
          pos_d = next_pos;
          rem_d = rem_q - POS_W'(1);
          if (rem_q == POS_W'(1) || abort_q || in_abort) begin
            rem_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            valid_d = 1'b1;
            incr_d  = dir_incr_q;
            decr_d  = ~dir_incr_q;
            state_d = S_STEP;
          end
`ifdef FINEPS_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          rem_d     = '0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        incr_d  = 1'b0;
        decr_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      rem_q      <= '0;
      dir_incr_q <= 1'b0;
      abort_q    <= 1'b0;
      valid_q    <= 1'b0;
      incr_q     <= 1'b0;
      decr_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      rem_q      <= rem_d;
      dir_incr_q <= dir_incr_d;
      abort_q    <= abort_d;
      valid_q    <= valid_d;
      incr_q     <= incr_d;
      decr_q     <= decr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

`ifdef FINEPS_TIMEOUT_EN
  // Dready wait counter and sticky timeout flag
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_timeout = timeout_q;
`else
  assign out_timeout = 1'b0;
`endif

  assign out_cmd_ready       = ready_q;
  assign out_fineps_incr     = incr_q;
  assign out_fineps_decr     = decr_q;
  assign out_fineps_valid    = valid_q;
  assign out_position        = pos_q;
  assign out_steps_remaining = rem_q;
  assign out_busy            = busy_q;
  assign out_done            = done_q;
  assign out_cmd_err         = err_q;

endmodule

// File: tb/tb_fine_phase_shift_sequencer.sv
// Directed bench for fine_phase_shift_sequencer with N=56 and a synthesizer
// model whose dready drops the cycle after an accept and returns 12 cycles later.
module tb_fine_phase_shift_sequencer;
  localparam int unsigned N  = 56;
  localparam int unsigned PW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [PW-1:0] cmd_target = '0;
  logic          cmd_ready;
  logic          abort_in = 1'b0;
  logic          incr, decr, valid, dready;
  logic [PW-1:0] position, steps_remaining;
  logic          busy, done, cmd_err, timeout;

  int total = 0;
  int bad = 0;

  fine_phase_shift_sequencer #(
    .INT_PS_STEPS_PER_PERIOD(N),
    .INT_TIMEOUT_CYCLES(64)
  ) dut (
    .in_clk(clk),
    .in_rst_n(rst_n),
    .in_cmd_valid(cmd_valid),
    .in_cmd_target(cmd_target),
    .out_cmd_ready(cmd_ready),
    .in_abort(abort_in),
    .out_fineps_incr(incr),
    .out_fineps_decr(decr),
    .out_fineps_valid(valid),
    .in_fineps_dready(dready),
    .out_position(position),
    .out_steps_remaining(steps_remaining),
    .out_busy(busy),
    .out_done(done),
    .out_cmd_err(cmd_err),
    .out_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Synthesizer model
  int unsigned busy_cnt = 0;
  bit never_return = 1'b0;
  bit force_low = 1'b0;
  assign dready = (busy_cnt == 0) && !force_low;

  always @(posedge clk) begin
    if (!rst_n) busy_cnt <= 0;
    else if (valid && dready) busy_cnt <= 12;
    else if (busy_cnt != 0 && !never_return) busy_cnt <= busy_cnt - 1;
  end

  // Cumulative monitors
  int inc_x = 0, dec_x = 0, dir_bad = 0, done_n = 0, err_n = 0, tmo_seen = 0, valid_idle = 0;
  longint cyc = 0, last_x = 0;
  int min_gap = 1000000;
  bit have_x = 1'b0;
  logic [PW-1:0] prev_pos;
  int hist[$];

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    done_n <= done_n + int'(done);
    err_n  <= err_n + int'(cmd_err);
    if (timeout === 1'b1) tmo_seen <= tmo_seen + 1;
    if (valid === 1'b1 && busy !== 1'b1) valid_idle <= valid_idle + 1;
    if (valid && dready) begin
      if (incr && !decr)      inc_x <= inc_x + 1;
      else if (decr && !incr) dec_x <= dec_x + 1;
      else                    dir_bad <= dir_bad + 1;
      if (have_x && int'(cyc - last_x) < min_gap) min_gap <= int'(cyc - last_x);
      last_x <= cyc;
      have_x <= 1'b1;
    end
    prev_pos <= position;
    if (position != prev_pos) hist.push_back(int'(position));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [PW-1:0] tgt);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        expired = 1'b0;
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (position !== 0) begin bad++; $display("FAIL reset_position: got %0d expected 0", position); end
    total++; if (steps_remaining !== 0) begin bad++; $display("FAIL reset_remaining: got %0d expected 0", steps_remaining); end
    total++; if ({cmd_ready, busy} !== 2'b10) begin bad++; $display("FAIL reset_ready_busy: got %b expected 10", {cmd_ready, busy}); end
    total++; if ({valid, incr, decr, done, cmd_err, timeout} !== 6'b0) begin bad++; $display("FAIL reset_outputs: got %b expected 000000", {valid, incr, decr, done, cmd_err, timeout}); end
  endtask

  task automatic test_incr_move();
    int i0, d0, n0, h0;
    bit to;
    i0 = inc_x; d0 = dec_x; n0 = done_n; h0 = hist.size();
    send_cmd(PW'(5));
    total++; if ({valid, incr, decr} !== 3'b110) begin bad++; $display("FAIL incr_first_req: got %b expected 110", {valid, incr, decr}); end
    total++; if (steps_remaining !== 5) begin bad++; $display("FAIL incr_remaining: got %0d expected 5", steps_remaining); end
    total++; if ({cmd_ready, busy} !== 2'b01) begin bad++; $display("FAIL incr_busy: got %b expected 01", {cmd_ready, busy}); end
    wait_idle(400, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL incr_timeout_wait: got %0d expected 0", to); end
    total++; if (inc_x - i0 !== 5 || dec_x - d0 !== 0) begin bad++; $display("FAIL incr_steps: got inc=%0d dec=%0d expected inc=5 dec=0", inc_x - i0, dec_x - d0); end
    total++; if (done_n - n0 !== 1) begin bad++; $display("FAIL incr_done: got %0d expected 1", done_n - n0); end
    total++; if (position !== 5) begin bad++; $display("FAIL incr_position: got %0d expected 5", position); end
    total++; if (min_gap < 13) begin bad++; $display("FAIL incr_gap: got %0d expected >=13", min_gap); end
    total++;
    if (hist.size() != h0 + 5) begin
      bad++; $display("FAIL incr_hist_len: got %0d expected %0d", hist.size() - h0, 5);
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++; if (hist[h0 + k] != k + 1) begin bad++; $display("FAIL incr_hist[%0d]: got %0d expected %0d", k, hist[h0 + k], k + 1); end
      end
    end
  endtask

  task automatic test_decr_wrap();
    int i0, d0, h0;
    bit to;
    i0 = inc_x; d0 = dec_x; h0 = hist.size();
    send_cmd(PW'(50));
    total++; if ({valid, incr, decr} !== 3'b101) begin bad++; $display("FAIL decr_first_req: got %b expected 101", {valid, incr, decr}); end
    total++; if (steps_remaining !== 11) begin bad++; $display("FAIL decr_remaining: got %0d expected 11", steps_remaining); end
    wait_idle(600, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL decr_timeout_wait: got %0d expected 0", to); end
    total++; if (dec_x - d0 !== 11 || inc_x - i0 !== 0) begin bad++; $display("FAIL decr_steps: got dec=%0d inc=%0d expected dec=11 inc=0", dec_x - d0, inc_x - i0); end
    total++; if (position !== 50) begin bad++; $display("FAIL decr_position: got %0d expected 50", position); end
    total++;
    if (hist.size() != h0 + 11) begin
      bad++; $display("FAIL decr_hist_len: got %0d expected 11", hist.size() - h0);
    end else if (hist[h0 + 4] != 0 || hist[h0 + 5] != 55) begin
      bad++; $display("FAIL decr_wrap: got %0d,%0d expected 0,55", hist[h0 + 4], hist[h0 + 5]);
    end
    i0 = inc_x;
    send_cmd(PW'(0));
    wait_idle(400, to);
    total++; if (inc_x - i0 !== 6 || position !== 0) begin bad++; $display("FAIL incr_wrap_to_0: got inc=%0d pos=%0d expected inc=6 pos=0", inc_x - i0, position); end
  endtask

  task automatic test_tie_and_zero();
    int i0, d0, n0;
    bit to;
    i0 = inc_x; d0 = dec_x;
    send_cmd(PW'(28));
    total++; if ({valid, incr, decr} !== 3'b110 || steps_remaining !== 28) begin bad++; $display("FAIL tie_req: got vid=%b rem=%0d expected 110 rem=28", {valid, incr, decr}, steps_remaining); end
    wait_idle(1000, to);
    total++; if (to !== 1'b0 || inc_x - i0 !== 28 || dec_x - d0 !== 0 || position !== 28) begin bad++; $display("FAIL tie_move: got to=%0d inc=%0d dec=%0d pos=%0d expected 0/28/0/28", to, inc_x - i0, dec_x - d0, position); end
    i0 = inc_x; d0 = dec_x;
    send_cmd(PW'(0));
    wait_idle(1000, to);
    total++; if (to !== 1'b0 || inc_x - i0 !== 28 || dec_x - d0 !== 0 || position !== 0) begin bad++; $display("FAIL tie_back: got to=%0d inc=%0d dec=%0d pos=%0d expected 0/28/0/0", to, inc_x - i0, dec_x - d0, position); end
    i0 = inc_x; d0 = dec_x; n0 = done_n;
    send_cmd(PW'(0));
    total++; if ({done, busy, valid} !== 3'b100) begin bad++; $display("FAIL zero_move_done: got %b expected 100", {done, busy, valid}); end
    repeat (3) @(negedge clk);
    total++; if (done_n - n0 !== 1 || inc_x - i0 + dec_x - d0 !== 0) begin bad++; $display("FAIL zero_move_count: got done=%0d steps=%0d expected 1/0", done_n - n0, inc_x - i0 + dec_x - d0); end
  endtask

  task automatic test_cmd_err();
    int i0, d0, e0;
    i0 = inc_x; d0 = dec_x; e0 = err_n;
    send_cmd(PW'(60));
    total++; if ({cmd_err, busy, done, valid} !== 4'b1000) begin bad++; $display("FAIL err_pulse: got %b expected 1000", {cmd_err, busy, done, valid}); end
    @(negedge clk);
    total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got %b expected 0", cmd_err); end
    repeat (3) @(negedge clk);
    total++; if (err_n - e0 !== 1 || inc_x - i0 + dec_x - d0 !== 0 || position !== 0) begin bad++; $display("FAIL err_effect: got err=%0d steps=%0d pos=%0d expected 1/0/0", err_n - e0, inc_x - i0 + dec_x - d0, position); end
  endtask

  task automatic test_ignored_busy();
    int i0, n0;
    bit to;
    i0 = inc_x; n0 = done_n;
    send_cmd(PW'(3));
    repeat (5) @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b expected 0", cmd_ready); end
    cmd_valid = 1'b1; cmd_target = PW'(10);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle(400, to);
    total++; if (to !== 1'b0 || position !== 3 || inc_x - i0 !== 3 || done_n - n0 !== 1) begin bad++; $display("FAIL busy_ignored: got to=%0d pos=%0d inc=%0d done=%0d expected 0/3/3/1", to, position, inc_x - i0, done_n - n0); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL busy_ready_after: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_abort_wait();
    int i0, n0;
    bit to;
    i0 = inc_x; n0 = done_n;
    send_cmd(PW'(13));
    total++; if (steps_remaining !== 10) begin bad++; $display("FAIL abortw_remaining: got %0d expected 10", steps_remaining); end
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (inc_x - i0 == 3) begin to = 1'b0; break; end
      @(negedge clk);
    end
    total++; if (to !== 1'b0) begin bad++; $display("FAIL abortw_reach_step3: got inc=%0d expected 3", inc_x - i0); end
    repeat (2) @(negedge clk);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    wait_idle(200, to);
    total++; if (to !== 1'b0 || inc_x - i0 !== 3 || position !== 6 || done_n - n0 !== 1) begin bad++; $display("FAIL abortw_result: got to=%0d inc=%0d pos=%0d done=%0d expected 0/3/6/1", to, inc_x - i0, position, done_n - n0); end
  endtask

  task automatic test_abort_step();
    int i0, n0;
    i0 = inc_x; n0 = done_n;
    force_low = 1'b1;
    send_cmd(PW'(10));
    repeat (2) @(negedge clk);
    total++; if ({valid, incr, busy} !== 3'b111) begin bad++; $display("FAIL aborts_hold: got %b expected 111", {valid, incr, busy}); end
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    total++; if ({done, busy, valid} !== 3'b100) begin bad++; $display("FAIL aborts_exit: got %b expected 100", {done, busy, valid}); end
    force_low = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (inc_x - i0 !== 0 || position !== 6 || done_n - n0 !== 1) begin bad++; $display("FAIL aborts_result: got inc=%0d pos=%0d done=%0d expected 0/6/1", inc_x - i0, position, done_n - n0); end
  endtask

  task automatic test_abort_with_transfer();
    int i0, n0;
    bit to;
    i0 = inc_x; n0 = done_n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_target = PW'(9); abort_in = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++; if ({valid, incr} !== 2'b11) begin bad++; $display("FAIL abortx_idle_ignored: got %b expected 11", {valid, incr}); end
    @(negedge clk);
    abort_in = 1'b0;
    wait_idle(200, to);
    total++; if (to !== 1'b0 || inc_x - i0 !== 1 || position !== 7 || done_n - n0 !== 1) begin bad++; $display("FAIL abortx_result: got to=%0d inc=%0d pos=%0d done=%0d expected 0/1/7/1", to, inc_x - i0, position, done_n - n0); end
  endtask

  task automatic test_timeout();
    int i0, n0;
    bit to;
`ifdef FINEPS_TIMEOUT_EN
    i0 = inc_x; n0 = done_n;
    never_return = 1'b1;
    send_cmd(PW'(9));
    wait_idle(300, to);
    total++; if (to !== 1'b0 || timeout !== 1'b1 || position !== 7 || inc_x - i0 !== 1 || done_n - n0 !== 1) begin bad++; $display("FAIL tmo_result: got to=%0d tmo=%b pos=%0d inc=%0d done=%0d expected 0/1/7/1/1", to, timeout, position, inc_x - i0, done_n - n0); end
    never_return = 1'b0;
    repeat (20) @(negedge clk);
    send_cmd(PW'(8));
    wait_idle(200, to);
    total++; if (to !== 1'b0 || position !== 8 || timeout !== 1'b1) begin bad++; $display("FAIL tmo_recover: got to=%0d pos=%0d tmo=%b expected 0/8/1", to, position, timeout); end
`else
    i0 = 0; n0 = 0; to = 1'b0;
    total++; if (timeout !== 1'b0 || tmo_seen !== 0) begin bad++; $display("FAIL tmo_tied_off: got tmo=%b seen=%0d expected 0/0", timeout, tmo_seen); end
`endif
  endtask

  initial begin
    test_reset();
    test_incr_move();
    test_decr_wrap();
    test_tie_and_zero();
    test_cmd_err();
    test_ignored_busy();
    test_abort_wait();
    test_abort_step();
    test_abort_with_transfer();
    test_timeout();
    total++; if (dir_bad !== 0) begin bad++; $display("FAIL dir_onehot: got %0d bad transfers expected 0", dir_bad); end
    total++; if (valid_idle !== 0) begin bad++; $display("FAIL valid_when_idle: got %0d cycles expected 0", valid_idle); end
    total++; if (min_gap < 13) begin bad++; $display("FAIL step_gap: got %0d expected >=13", min_gap); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fine_phase_shift_sequencer.md
Name: fine_phase_shift_sequencer

Overview:
Initiator side of the clock synthesizer's fine phase-shift handshake (incr/decr/valid in, dready out). Accepts an absolute target phase position, computes the shortest wrap-around path, and issues single-step incr or decr requests one at a time. Each request waits for dready to return. Tracks the current fine-PS position modulo one output-clock period, and runs in the fine-PS clock domain.

Parameters:
INT_PS_STEPS_PER_PERIOD, 504, number of fine-PS steps per full output-clock period (56 x CLKOUT divide); position wraps modulo this value; must be >= 2
INT_TIMEOUT_CYCLES, 64, max cycles waiting for dready after a step (used only with the optional feature)

Ports:
in_clk  input  1  fine-PS clock, same clock that drives the synthesizer's in_fineps_clk
in_rst_n  input  1  synchronous active-low reset
in_cmd_valid  input  1  target command valid
in_cmd_target  input  POS_W  absolute target position; POS_W = $clog2(INT_PS_STEPS_PER_PERIOD)
out_cmd_ready  output  1  high only in IDLE
in_abort  input  1  stop after the outstanding step completes
out_fineps_incr  output  1  to synthesizer in_fineps_incr
out_fineps_decr  output  1  to synthesizer in_fineps_decr
out_fineps_valid  output  1  to synthesizer in_fineps_valid
in_fineps_dready  input  1  from synthesizer out_fineps_dready
out_position  output  POS_W  current confirmed position
out_steps_remaining  output  POS_W  steps left in the current move
out_busy  output  1  high outside IDLE
out_done  output  1  one-cycle pulse when a move or abort finishes
out_cmd_err  output  1  one-cycle pulse when a command is rejected
out_timeout  output  1  sticky timeout flag (tied 0 without the optional feature)

Behaviour:
- Reset (in_rst_n=0 at posedge in_clk):
  - state=IDLE, position=0, steps_remaining=0.
  - All handshake and pulse outputs 0; out_cmd_ready=1 from the first cycle after reset; out_timeout=0.
- States are IDLE, STEP, WAIT_DONE.
- IDLE:
  - cmd accepted when in_cmd_valid & out_cmd_ready.
  - target >= N (N = INT_PS_STEPS_PER_PERIOD): out_cmd_err pulses next cycle, stay IDLE.
  - Otherwise d = (target - position) mod N:
    - d==0: out_done pulses next cycle, stay IDLE.
    - d <= N/2 (integer divide): direction=incr, remaining=d. A tie at d == N/2 therefore goes incr.
    - else: direction=decr, remaining=N-d.
    - Next state STEP.
- STEP:
  - out_fineps_valid=1; exactly one of incr/decr=1 per direction; valid and incr/decr are registered.
  - Transfer = valid & in_fineps_dready at the same posedge. Hold valid until transfer.
  - On transfer: drop valid next cycle, go to WAIT_DONE.
- WAIT_DONE:
  - valid=0, incr=decr=0. Minimum 1 cycle in this state, because the synthesizer's dready goes low the cycle after acceptance.
  - On in_fineps_dready=1 the step completes:
    - position += 1 (N-1 wraps to 0) or position -= 1 (0 wraps to N-1).
    - remaining -= 1.
    - If remaining becomes 0, or abort is latched: out_done pulse, go to IDLE.
    - Else go to STEP.
- Abort:
  - in_abort is sampled in STEP or WAIT_DONE and latched.
  - If asserted in STEP before transfer: drop valid, out_done pulse, IDLE, no position change.
  - If asserted in WAIT_DONE: finish the outstanding step (position updated), then IDLE.
  - Abort in IDLE is ignored.
- Simultaneous in_abort and transfer in STEP: the transfer wins (step is outstanding) and abort is latched; handled as WAIT_DONE abort.
- in_cmd_valid outside IDLE is ignored (ready=0); there is no queueing.
- Reset mid-move returns to IDLE with position=0. After reset the synthesizer MMCM must also be reset for positions to agree.
- out_position changes only on step completion, never on request.

Optional Feature:
FINEPS_TIMEOUT_EN:
- Defined:
  - A counter runs in WAIT_DONE.
  - If dready stays low for INT_TIMEOUT_CYCLES cycles: out_timeout=1 (sticky until reset), out_done pulses, go to IDLE, position is not updated.
  - Later commands are still accepted.
- Undefined: no counter; WAIT_DONE waits indefinitely; out_timeout tied 0.

Test Plan (bench uses N=56 and a synthesizer model whose dready drops 1 cycle after accept and returns 12 cycles later):
- Reset, cmd target=5 -> 5 incr transfers, each separated by >= 13 cycles; out_position 1..5; single out_done; out_position=5.
- From position 5, target=50 -> d=45 > 28, so 11 decr steps wrapping 0 -> 55; final position 50.
- From position 0, target=28 -> tie goes incr, 28 steps; target=0 when already at 0 -> out_done next cycle, no valid.
- target=60 -> out_cmd_err pulse, no valid, position unchanged; cmd_valid during busy -> ignored.
- in_abort asserted during WAIT_DONE of the 3rd step of a 10-step move -> position advances by exactly 3, out_done, then IDLE; in_abort in STEP pre-transfer -> no step.
- With FINEPS_TIMEOUT_EN, model never returns dready -> out_timeout=1 after 64 cycles, position unchanged, next command accepted.
